// File: rtl/spi_mem_bridge_if.sv
// Bundles the serdes-facing packet handshake and the RAM bank bus of spi_mem_bridge.
// master: the bridge side (drives addresses, write strobes and outPacket).
// slave: the environment side (serdes plus RAM banks).
interface spi_mem_bridge_if #(
    parameter int WORD_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 2,
    parameter int NUM_BANKS     = 1,
    parameter int ERR_CNT_WIDTH = 8
);
    localparam int PACKET_WIDTH = WORD_WIDTH + 4;
    localparam int BANK_BITS    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int RB           = (BANK_BITS > 0) ? BANK_BITS : 1;

    logic                            dataReady;
    logic [PACKET_WIDTH-1:0]         inPacket;
    logic [PACKET_WIDTH-1:0]         outPacket;
    logic [ADDR_WIDTH-1:0]           rd_addr;
    logic [RB-1:0]                   rd_bank;
    logic [NUM_BANKS*WORD_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0]           wr_addr;
    logic [WORD_WIDTH-1:0]           wr_data;
    logic [NUM_BANKS-1:0]            wr_enable;
    logic                            inPacketIsValid;
    logic [ERR_CNT_WIDTH-1:0]        err_count;

    modport master (
        input  dataReady, inPacket, rd_data,
        output outPacket, rd_addr, rd_bank, wr_addr, wr_data, wr_enable,
               inPacketIsValid, err_count
    );

    modport slave (
        output dataReady, inPacket, rd_data,
        input  outPacket, rd_addr, rd_bank, wr_addr, wr_data, wr_enable,
               inPacketIsValid, err_count
    );
endinterface

// File: rtl/spi_mem_bridge.sv
// Decodes framed SPI packets into read address, write address and data words for NUM_BANKS RAMs.
// Latency: pointers/write strobe one cycle after dataReady; outPacket reloaded three cycles after.
// No backpressure: serdes strobes are assumed at least three cycles apart.
module spi_mem_bridge #(
    parameter int WORD_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 2,
    parameter int NUM_BANKS     = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    spi_mem_bridge_if.master  bus
);
    localparam int P         = WORD_WIDTH + 4;
    localparam int HALF      = P / 2;
    localparam int HW        = WORD_WIDTH / 2;
    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int RB        = (BANK_BITS > 0) ? BANK_BITS : 1;

    if (ADDR_WIDTH + BANK_BITS > WORD_WIDTH) begin : g_bad_cfg
        $error("spi_mem_bridge: ADDR_WIDTH + bank bits must fit in WORD_WIDTH");
    end

    typedef enum logic [1:0] {RD_ADDR, WR_ADDR, DATA} state_t;

    state_t                   state_q, state_d;
    logic                     ld_rd, ld_wr, do_wr;
    logic                     frame_ok;
    logic [WORD_WIDTH-1:0]    word;
    logic [ADDR_WIDTH-1:0]    word_addr;
    logic [RB-1:0]            word_bank;
    logic [ADDR_WIDTH-1:0]    rd_addr_q, wr_ptr_q, wr_addr_q;
    logic [RB-1:0]            rd_bank_q, wr_bank_q;
    logic [WORD_WIDTH-1:0]    wr_data_q;
    logic [NUM_BANKS-1:0]     wr_en_q;
    logic                     valid_q;
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic [1:0]               reload_pipe;
    logic [P-1:0]             out_q;

    // Two marker bit-pairs: 01 at the top, 10 at the top of the lower half.
    function automatic logic [P-1:0] frame(input logic [WORD_WIDTH-1:0] w);
        return {2'b01, w[WORD_WIDTH-1:HW], 2'b10, w[HW-1:0]};
    endfunction

    assign frame_ok  = (bus.inPacket[P-1:P-2] == 2'b01) &&
                       (bus.inPacket[HALF-1:HALF-2] == 2'b10);
    assign word      = {bus.inPacket[P-3:HALF], bus.inPacket[HALF-3:0]};
    assign word_addr = word[ADDR_WIDTH-1:0];

    if (BANK_BITS > 0) begin : g_bank
        assign word_bank = word[ADDR_WIDTH +: BANK_BITS];
    end else begin : g_nobank
        assign word_bank = 1'b0;
    end

    // State register: packet role sequence RD_ADDR -> WR_ADDR -> DATA (sticky).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RD_ADDR;
        else       state_q <= state_d;
    end

    // Next-state and per-packet actions; only a well-framed strobe advances.
    always_comb begin
        state_d = state_q;
        ld_rd   = 1'b0;
        ld_wr   = 1'b0;
        do_wr   = 1'b0;
        if (bus.dataReady && frame_ok) begin
            case (state_q)
                RD_ADDR: begin ld_rd = 1'b1; state_d = WR_ADDR; end
                WR_ADDR: begin ld_wr = 1'b1; state_d = DATA;    end
                DATA:    begin do_wr = 1'b1;                    end
                default: state_d = RD_ADDR;
            endcase
        end
    end

    // Read/write pointers; increments wrap within the bank, bank is never touched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q <= '0;
            rd_bank_q <= '0;
            wr_ptr_q  <= '0;
            wr_bank_q <= '0;
        end else if (ld_rd) begin
            rd_addr_q <= word_addr;
            rd_bank_q <= word_bank;
        end else if (ld_wr) begin
            wr_ptr_q  <= word_addr;
            wr_bank_q <= word_bank;
        end else if (do_wr) begin
            wr_ptr_q  <= wr_ptr_q + 1'b1;
            rd_addr_q <= rd_addr_q + 1'b1;
        end
    end

    // One-cycle write strobe to the selected bank at the pre-increment pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (do_wr) begin
            wr_en_q   <= NUM_BANKS'(1) << wr_bank_q;
            wr_addr_q <= wr_ptr_q;
            wr_data_q <= word;
        end else begin
            wr_en_q   <= '0;
        end
    end

    // Framing status of the latest strobe and saturating bad-packet count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            err_q   <= '0;
        end else if (bus.dataReady) begin
            valid_q <= frame_ok;
            if (!frame_ok && (err_q != '1)) err_q <= err_q + 1'b1;
        end
    end

    // Read-back: wait for the new address to reach the RAM, then its data, then frame it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_pipe <= '0;
            out_q       <= frame('0);
        end else begin
            reload_pipe <= {reload_pipe[0], ld_rd | do_wr};
            if (reload_pipe[1])
                out_q <= frame(bus.rd_data[rd_bank_q*WORD_WIDTH +: WORD_WIDTH]);
        end
    end

    assign bus.outPacket       = out_q;
    assign bus.rd_addr         = rd_addr_q;
    assign bus.rd_bank         = rd_bank_q;
    assign bus.wr_addr         = wr_addr_q;
    assign bus.wr_data         = wr_data_q;
    assign bus.wr_enable       = wr_en_q;
    assign bus.inPacketIsValid = valid_q;
    assign bus.err_count       = err_q;
endmodule
